// File: rtl/tangle_operand_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tangle_operand_stage_pkg
//  Description : Shared constants, instruction fields and opcode helpers for
//                the tangle operand/writeback stage.
//  Revision    : 1.0
// ============================================================================
package tangle_operand_stage_pkg;

    localparam int DATA_W = 16;
    localparam int NREGS  = 8;
    localparam int ADDR_W = 3;
    localparam int OPC_W  = 4;
    localparam int IMM_W  = 8;

    // Instruction field positions; rs and imm8 deliberately overlap.
    localparam int OPC_HI = 15;
    localparam int OPC_LO = 12;
    localparam int RD_HI  = 11;
    localparam int RD_LO  = 9;
    localparam int RS_HI  = 8;
    localparam int RS_LO  = 6;
    localparam int IMM_HI = 7;
    localparam int IMM_LO = 0;

    localparam logic [OPC_W-1:0] OP_OR    = 4'd0;
    localparam logic [OPC_W-1:0] OP_AND   = 4'd1;
    localparam logic [OPC_W-1:0] OP_XOR   = 4'd2;
    localparam logic [OPC_W-1:0] OP_SLL   = 4'd3;
    localparam logic [OPC_W-1:0] OP_SLR   = 4'd4;
    localparam logic [OPC_W-1:0] OP_NOT   = 4'd5;
    localparam logic [OPC_W-1:0] OP_NEG   = 4'd6;
    localparam logic [OPC_W-1:0] OP_ADD   = 4'd7;
    localparam logic [OPC_W-1:0] OP_SUB   = 4'd8;
    localparam logic [OPC_W-1:0] OP_CMP   = 4'd9;
    localparam logic [OPC_W-1:0] OP_MOV   = 4'd10;
    localparam logic [OPC_W-1:0] OP_MOVHI = 4'd11;
    localparam logic [OPC_W-1:0] OP_MOVLO = 4'd12;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_EXEC = ST_EXEC,
        S_DONE = ST_DONE
    } state_e;

    typedef struct packed {
        logic [OPC_W-1:0]  opc;
        logic [ADDR_W-1:0] rd;
        logic [ADDR_W-1:0] rs;
        logic [IMM_W-1:0]  imm;
    } instr_fields_t;

    function automatic instr_fields_t decode_instr(input logic [DATA_W-1:0] w);
        instr_fields_t f;
        f.opc = w[OPC_HI:OPC_LO];
        f.rd  = w[RD_HI:RD_LO];
        f.rs  = w[RS_HI:RS_LO];
        f.imm = w[IMM_HI:IMM_LO];
        return f;
    endfunction

    // Shifts are not supported by this stage and are retired as illegal.
    function automatic logic opc_is_legal(input logic [OPC_W-1:0] op);
        return !((op == OP_SLL) || (op == OP_SLR) || (op > OP_MOVLO));
    endfunction

    function automatic logic opc_writes_back(input logic [OPC_W-1:0] op);
        return opc_is_legal(op) && (op != OP_CMP);
    endfunction

endpackage
`default_nettype wire

// File: rtl/tangle_regfile.sv
`default_nettype none
// ============================================================================
//  Module      : tangle_regfile
//  Description : General register file, two async read ports, one debug read
//                port and one synchronous write port with synchronous clear.
//  Revision    : 1.0
// ============================================================================
module tangle_regfile #(
    parameter int DATA_W = 16,
    parameter int NREGS  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_a_i,
    input  logic [ADDR_W-1:0] raddr_b_i,
    input  logic [ADDR_W-1:0] dbg_addr_i,
    output logic [DATA_W-1:0] rdata_a_o,
    output logic [DATA_W-1:0] rdata_b_o,
    output logic [DATA_W-1:0] dbg_data_o
);

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];

    always_comb begin
        regs_d = regs_q;
        if (we_i) begin
            regs_d[waddr_i] = wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Reads see the pre-write value, so rd==rs sources the old contents.
    assign rdata_a_o  = regs_q[raddr_a_i];
    assign rdata_b_o  = regs_q[raddr_b_i];
    assign dbg_data_o = regs_q[dbg_addr_i];

endmodule
`default_nettype wire

// File: rtl/tangle_operand_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tangle_operand_stage
//  Description : Single-issue operand fetch, ALU drive and writeback stage.
//                Sequence per instruction: IDLE (accept) -> EXEC -> DONE.
//  Revision    : 1.0
// ============================================================================
module tangle_operand_stage
    import tangle_operand_stage_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [DATA_W-1:0] instr_i,
    input  logic              instr_valid_i,
    output logic              instr_ready_o,
    output logic [OPC_W-1:0]  alu_op_o,
    output logic [DATA_W-1:0] alu_data1_o,
    output logic [DATA_W-1:0] alu_data2_o,
    output logic              alu_en_o,
    input  logic [DATA_W-1:0] alu_result_i,
    output logic              done_o,
    output logic              illegal_o,
    input  logic [ADDR_W-1:0] dbg_addr_i,
    output logic [DATA_W-1:0] dbg_data_o
);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] instr_q, instr_d;

    instr_fields_t     fields;
    logic              legal;
    logic              rf_we;
    logic [DATA_W-1:0] rdata_a;
    logic [DATA_W-1:0] rdata_b;
    logic [DATA_W-1:0] imm_ext;

    assign fields  = decode_instr(instr_q);
    assign legal   = opc_is_legal(fields.opc);
    assign imm_ext = {{(DATA_W-IMM_W){1'b0}}, fields.imm};

    tangle_regfile #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS),
        .ADDR_W (ADDR_W)
    ) u_regfile (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .we_i       (rf_we),
        .waddr_i    (fields.rd),
        .wdata_i    (alu_result_i),
        .raddr_a_i  (fields.rd),
        .raddr_b_i  (fields.rs),
        .dbg_addr_i (dbg_addr_i),
        .rdata_a_o  (rdata_a),
        .rdata_b_o  (rdata_b),
        .dbg_data_o (dbg_data_o)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        instr_d       = instr_q;
        instr_ready_o = 1'b0;
        alu_op_o      = '0;
        alu_data1_o   = '0;
        alu_data2_o   = '0;
        alu_en_o      = 1'b0;
        done_o        = 1'b0;
        illegal_o     = 1'b0;
        rf_we         = 1'b0;

        case (state_q)
            S_IDLE: begin
                instr_ready_o = 1'b1;
                if (instr_valid_i) begin
                    instr_d = instr_i;
                    state_d = S_EXEC;
                end
            end

            S_EXEC: begin
                alu_op_o = fields.opc;
                // Illegal opcodes leave the ALU disabled so its flags hold.
                if (legal) begin
                    alu_en_o = 1'b1;
                    rf_we    = opc_writes_back(fields.opc);
                    case (fields.opc)
                        OP_NOT, OP_NEG: begin
                            alu_data1_o = rdata_a;
                        end
                        OP_MOV: begin
                            alu_data2_o = rdata_b;
                        end
                        OP_MOVHI: begin
                            alu_data2_o = imm_ext;
                        end
                        OP_MOVLO: begin
                            alu_data1_o = rdata_a & 16'hFF00;
                            alu_data2_o = imm_ext;
                        end
                        OP_OR, OP_AND, OP_XOR, OP_ADD, OP_SUB, OP_CMP: begin
                            alu_data1_o = rdata_a;
                            alu_data2_o = rdata_b;
                        end
                        default: begin
                            alu_data1_o = '0;
                            alu_data2_o = '0;
                        end
                    endcase
                end
                state_d = S_DONE;
            end

            S_DONE: begin
                done_o    = 1'b1;
                illegal_o = !legal;
                state_d   = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_tangle_operand_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tangle_operand_stage
//  Description : Directed bench with an ALU environment model and an
//                instruction-level reference model of the stage.
//  Revision    : 1.0
// ============================================================================
module tb_tangle_operand_stage;

    localparam int HALF = 10;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic [15:0] instr_i = '0;
    logic        instr_valid_i = 1'b0;
    logic        instr_ready_o;
    logic [3:0]  alu_op_o;
    logic [15:0] alu_data1_o;
    logic [15:0] alu_data2_o;
    logic        alu_en_o;
    logic [15:0] alu_result_i;
    logic        done_o;
    logic        illegal_o;
    logic [2:0]  dbg_addr_i = '0;
    logic [15:0] dbg_data_o;

    int n_cmp  = 0;
    int n_fail = 0;

    always #HALF clk = ~clk;

    tangle_operand_stage dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .instr_i       (instr_i),
        .instr_valid_i (instr_valid_i),
        .instr_ready_o (instr_ready_o),
        .alu_op_o      (alu_op_o),
        .alu_data1_o   (alu_data1_o),
        .alu_data2_o   (alu_data2_o),
        .alu_en_o      (alu_en_o),
        .alu_result_i  (alu_result_i),
        .done_o        (done_o),
        .illegal_o     (illegal_o),
        .dbg_addr_i    (dbg_addr_i),
        .dbg_data_o    (dbg_data_o)
    );

    // ---------------- ALU environment: comb result, registered flags -------
    logic [16:0] alu_t;
    logic        alu_cf, alu_of;
    logic        zf_q = 1'b0, cf_q = 1'b0, of_q = 1'b0, sf_q = 1'b0;

    always_comb begin
        alu_t        = '0;
        alu_result_i = '0;
        alu_cf       = 1'b0;
        alu_of       = 1'b0;
        case (alu_op_o)
            4'd0: alu_result_i = alu_data1_o | alu_data2_o;
            4'd1: alu_result_i = alu_data1_o & alu_data2_o;
            4'd2: alu_result_i = alu_data1_o ^ alu_data2_o;
            4'd5: alu_result_i = ~alu_data1_o;
            4'd6: begin
                alu_result_i = 16'h0000 - alu_data1_o;
                alu_cf       = (alu_data1_o != 16'h0000);
                alu_of       = (alu_data1_o == 16'h8000);
            end
            4'd7: begin
                alu_t        = {1'b0, alu_data1_o} + {1'b0, alu_data2_o};
                alu_result_i = alu_t[15:0];
                alu_cf       = alu_t[16];
                alu_of       = (alu_data1_o[15] == alu_data2_o[15]) && (alu_t[15] != alu_data1_o[15]);
            end
            4'd8, 4'd9: begin
                alu_t        = {1'b0, alu_data1_o} - {1'b0, alu_data2_o};
                alu_result_i = alu_t[15:0];
                alu_cf       = alu_t[16];
                alu_of       = (alu_data1_o[15] != alu_data2_o[15]) && (alu_t[15] != alu_data1_o[15]);
            end
            4'd10: alu_result_i = alu_data2_o;
            4'd11: alu_result_i = {alu_data2_o[7:0], 8'h00};
            4'd12: alu_result_i = {alu_data1_o[15:8], alu_data2_o[7:0]};
            default: alu_result_i = '0;
        endcase
    end

    always @(posedge clk) begin
        if (rst_i) begin
            zf_q <= 1'b0; cf_q <= 1'b0; of_q <= 1'b0; sf_q <= 1'b0;
        end else if (alu_en_o) begin
            zf_q <= (alu_result_i == 16'h0000);
            sf_q <= alu_result_i[15];
            cf_q <= alu_cf;
            of_q <= alu_of;
        end
    end

    // ---------------- reference model (instruction level) -----------------
    function automatic bit ref_legal(input logic [3:0] op);
        return op inside {4'd0, 4'd1, 4'd2, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11, 4'd12};
    endfunction

    function automatic logic [15:0] ref_result(input logic [3:0] op, input logic [15:0] a,
                                               input logic [15:0] b, input logic [7:0] imm);
        case (op)
            4'd0:    return a | b;
            4'd1:    return a & b;
            4'd2:    return a ^ b;
            4'd5:    return ~a;
            4'd6:    return 16'h0000 - a;
            4'd7:    return a + b;
            4'd8:    return a - b;
            4'd10:   return b;
            4'd11:   return {imm, 8'h00};
            4'd12:   return {a[15:8], imm};
            default: return 16'h0000;
        endcase
    endfunction

    function automatic logic [31:0] ref_operands(input logic [3:0] op, input logic [15:0] a,
                                                 input logic [15:0] b, input logic [7:0] imm);
        case (op)
            4'd0, 4'd1, 4'd2, 4'd7, 4'd8, 4'd9: return {a, b};
            4'd5, 4'd6: return {a, 16'h0000};
            4'd10:      return {16'h0000, b};
            4'd11:      return {16'h0000, 8'h00, imm};
            4'd12:      return {a & 16'hFF00, 8'h00, imm};
            default:    return 32'h0;
        endcase
    endfunction

    logic [15:0] m_regs [8];
    logic [15:0] m_cur = '0;
    int          m_age = 3;       // cycles since the accepting edge, saturating at 3
    bit          m_started = 1'b0;

    always @(posedge clk) begin
        if (rst_i) begin
            for (int i = 0; i < 8; i++) m_regs[i] <= '0;
            m_age     <= 3;
            m_started <= 1'b1;
        end else if (m_started) begin
            if (m_age == 1 && ref_legal(m_cur[15:12]) && m_cur[15:12] != 4'd9)
                m_regs[m_cur[11:9]] <= ref_result(m_cur[15:12], m_regs[m_cur[11:9]],
                                                  m_regs[m_cur[8:6]], m_cur[7:0]);
            if (m_age >= 3 && instr_valid_i) begin
                m_cur <= instr_i;
                m_age <= 1;
            end else if (m_age < 3) begin
                m_age <= m_age + 1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin : compare
        logic [3:0]  op;
        logic        lg;
        logic [31:0] ops;
        if (m_started) begin
            op  = m_cur[15:12];
            lg  = ref_legal(op);
            ops = (m_age == 1) ? ref_operands(op, m_regs[m_cur[11:9]], m_regs[m_cur[8:6]], m_cur[7:0]) : 32'h0;
            chk("ready",   32'(instr_ready_o), 32'(m_age >= 3));
            chk("done",    32'(done_o),        32'(m_age == 2));
            chk("illegal", 32'(illegal_o),     32'(m_age == 2 && !lg));
            chk("alu_en",  32'(alu_en_o),      32'(m_age == 1 && lg));
            chk("alu_op",  32'(alu_op_o),      32'((m_age == 1) ? op : 4'd0));
            if (m_age != 1 || lg) begin
                chk("alu_data1", 32'(alu_data1_o), 32'(ops[31:16]));
                chk("alu_data2", 32'(alu_data2_o), 32'(ops[15:0]));
            end
            chk("dbg_data", 32'(dbg_data_o), 32'(m_regs[dbg_addr_i]));
        end
    end

    // ---------------- stimulus -------------------------------------------
    logic s_rdy_exec, s_rdy_done, s_done_exec, s_done, s_ill;
    logic [3:0] s_flags;   // {zf, cf, of, sf} as seen in DONE

    function automatic logic [15:0] enc_rr(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs);
        return {op, rd, rs, 6'b0};
    endfunction

    function automatic logic [15:0] enc_ri(input logic [3:0] op, input logic [2:0] rd, input logic [7:0] imm);
        return {op, rd, 1'b0, imm};
    endfunction

    task automatic chk_reg(input string name, input logic [2:0] addr, input logic [15:0] exp);
        dbg_addr_i = addr;
        #1;
        chk(name, 32'(dbg_data_o), 32'(exp));
    endtask

    task automatic issue(input logic [15:0] ins);
        int n = 0;
        while (!instr_ready_o && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        if (!instr_ready_o) begin
            n_cmp++; n_fail++;
            $display("FAIL issue_ready_timeout: ready=%0b after %0d cycles, required 1", instr_ready_o, n);
        end
        dbg_addr_i    = ins[11:9];
        instr_i       = ins;
        instr_valid_i = 1'b1;
        @(posedge clk); #1;
        instr_valid_i = 1'b0;
        s_rdy_exec    = instr_ready_o;
        s_done_exec   = done_o;
        @(posedge clk); #1;
        s_rdy_done = instr_ready_o;
        s_done     = done_o;
        s_ill      = illegal_o;
        s_flags    = {zf_q, cf_q, of_q, sf_q};
        @(posedge clk); #1;
    endtask

    task automatic load(input logic [2:0] rd, input logic [15:0] v);
        issue(enc_ri(4'd11, rd, v[15:8]));
        issue(enc_ri(4'd12, rd, v[7:0]));
    endtask

    logic [15:0] held [3];
    logic [3:0]  saved_flags;
    logic        rdy;
    int          idx, ndone;

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst_i = 1'b0;

        chk("rst_ready",   32'(instr_ready_o), 32'd1);
        chk("rst_done",    32'(done_o),        32'd0);
        chk("rst_alu_en",  32'(alu_en_o),      32'd0);
        chk("rst_illegal", 32'(illegal_o),     32'd0);
        chk_reg("rst_r1", 3'd1, 16'h0000);

        // MOVHI/MOVLO build, with latency/ready timing pinned
        issue(enc_ri(4'd11, 3'd1, 8'h12));
        chk("movhi_rdy_exec",  32'(s_rdy_exec),  32'd0);
        chk("movhi_rdy_done",  32'(s_rdy_done),  32'd0);
        chk("movhi_done_exec", 32'(s_done_exec), 32'd0);
        chk("movhi_done",      32'(s_done),      32'd1);
        chk_reg("movhi_r1", 3'd1, 16'h1200);
        issue(enc_ri(4'd12, 3'd1, 8'h34));
        chk("movlo_done", 32'(s_done), 32'd1);
        chk_reg("movlo_r1", 3'd1, 16'h1234);

        // ADD with carry-out wrapping to zero
        load(3'd1, 16'hFFFF);
        load(3'd2, 16'h0001);
        issue(enc_rr(4'd7, 3'd1, 3'd2));
        chk("add_flags", 32'(s_flags), 32'(4'b1100));
        chk_reg("add_r1", 3'd1, 16'h0000);

        // CMP: signed overflow, no writeback
        load(3'd3, 16'h8000);
        load(3'd4, 16'h0001);
        issue(enc_rr(4'd9, 3'd3, 3'd4));
        chk("cmp_of", 32'(s_flags[1]), 32'd1);
        chk("cmp_sf", 32'(s_flags[0]), 32'd0);
        chk("cmp_zf", 32'(s_flags[3]), 32'd0);
        chk_reg("cmp_r3", 3'd3, 16'h8000);

        // Illegal opcodes: SLL and encoding 15
        load(3'd5, 16'h00AA);
        saved_flags = {zf_q, cf_q, of_q, sf_q};
        issue(enc_rr(4'd3, 3'd5, 3'd5));
        chk("sll_illegal", 32'(s_ill),   32'd1);
        chk("sll_done",    32'(s_done),  32'd1);
        chk("sll_flags",   32'(s_flags), 32'(saved_flags));
        chk_reg("sll_r5", 3'd5, 16'h00AA);
        issue(enc_rr(4'd15, 3'd5, 3'd1));
        chk("op15_illegal", 32'(s_ill), 32'd1);
        chk_reg("op15_r5", 3'd5, 16'h00AA);

        // Held valid across three back-to-back instructions
        load(3'd6, 16'h000F);
        load(3'd7, 16'h0019);
        load(3'd0, 16'h0003);
        held[0] = enc_rr(4'd2, 3'd6, 3'd7);
        held[1] = enc_rr(4'd6, 3'd0, 3'd0);
        held[2] = enc_rr(4'd7, 3'd2, 3'd2);
        idx = 0; ndone = 0;
        dbg_addr_i    = 3'd6;
        instr_i       = held[0];
        instr_valid_i = 1'b1;
        for (int c = 0; c < 30 && idx < 3; c++) begin
            rdy = instr_ready_o;
            @(posedge clk); #1;
            if (rdy) begin
                idx++;
                if (idx < 3) instr_i = held[idx];
            end
            if (done_o) ndone++;
        end
        instr_valid_i = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            if (done_o) ndone++;
        end
        chk("held_accepts", 32'(idx), 32'd3);
        chk("held_dones",   32'(ndone), 32'd3);
        chk_reg("xor_r6", 3'd6, 16'h0016);
        chk_reg("neg_r0", 3'd0, 16'hFFFD);
        chk_reg("add_r2", 3'd2, 16'h0002);

        // Reset during EXEC aborts the ADD
        dbg_addr_i    = 3'd3;
        instr_i       = enc_rr(4'd7, 3'd3, 3'd4);
        instr_valid_i = 1'b1;
        @(posedge clk); #1;
        instr_valid_i = 1'b0;
        rst_i         = 1'b1;
        @(posedge clk); #1;
        rst_i = 1'b0;
        chk("abort_ready", 32'(instr_ready_o), 32'd1);
        chk("abort_done",  32'(done_o),        32'd0);
        for (int i = 0; i < 8; i++) chk_reg("abort_reg_clear", 3'(i), 16'h0000);
        repeat (4) @(posedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #(2 * HALF * 5000);
        $display("FAIL watchdog: simulation did not complete, compared=%0d mismatched=%0d", n_cmp, n_fail);
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/tangle_operand_stage.md
Name: tangle_operand_stage

Overview:
- Single-issue operand/writeback stage that sits directly upstream of the ALU and also consumes the ALU's result.
- Accepts one 16-bit instruction per handshake and decodes it.
- Reads source operands from an internal 8x16 register file and drives the ALU's op/data/enable inputs for exactly one cycle.
- Writes the ALU result back to the destination register, then signals completion once the ALU flag registers have updated.

Parameters:
- DATA_W, 16, register and operand width (fixed to the ALU width).
- NREGS, 8, number of general registers (address width 3, fixed).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, synchronous, active-high.
- instr_i  in  16  instruction word.
  - [15:12] opcode.
  - [11:9] rd.
  - [8:6] rs.
  - [7:0] imm8, used by MOVHI/MOVLO only.
- instr_valid_i  in  1  instr_i is valid.
- instr_ready_o  out  1  stage can accept an instruction.
- alu_op_o  out  4  to ALU op_i.
- alu_data1_o  out  16  to ALU data1_i.
- alu_data2_o  out  16  to ALU data2_i.
- alu_en_o  out  1  to ALU alu_en.
- alu_result_i  in  16  from ALU data_o.
- done_o  out  1  one-cycle pulse: instruction retired, ALU flags valid.
- illegal_o  out  1  one-cycle pulse with done_o for an unsupported opcode.
- dbg_addr_i  in  3  debug register read address.
- dbg_data_o  out  16  combinational read of regfile[dbg_addr_i].

Behaviour:
- Reset is synchronous and active-high.
  - State goes to IDLE; all 8 registers clear to 0.
  - The latched instruction clears to 0.
  - All outputs are 0, except instr_ready_o, which is 1.
- Reset mid-operation aborts the instruction: no writeback and no done_o.
- FSM IDLE -> EXEC -> DONE -> IDLE.
- IDLE:
  - instr_ready_o=1.
  - On instr_valid_i=1, instr_i is latched and the FSM moves to EXEC.
  - In any other state instr_ready_o=0, so a held instr_valid_i is ignored until IDLE.
- EXEC (exactly one cycle):
  - alu_en_o=1 for legal opcodes.
  - alu_op_o = latched opcode.
  - Operands are read combinationally from the register file; a = reg[rd], b = reg[rs].
- Operand mapping:
  - OR/AND/XOR/ADD/SUB/CMP: data1=a, data2=b.
  - NOT/NEG: data1=a, data2=0.
  - MOV: data1=0, data2=b.
  - MOVHI: data1=0, data2={8'h00,imm8}.
  - MOVLO: data1=a & 16'hFF00, data2={8'h00,imm8}. The low byte is replaced and the high byte is kept.
- Writeback at the end of the EXEC cycle: reg[rd] <= alu_result_i for every legal opcode except CMP. CMP updates flags only.
- Illegal opcodes (SLL, SLR, and encodings 13-15):
  - alu_en_o=0 in EXEC, so ALU flags are untouched.
  - No writeback.
  - illegal_o=1 in DONE.
- DONE (one cycle):
  - done_o=1.
  - alu_en_o=0 and the ALU outputs are driven to 0.
  - The ALU flags were registered at the EXEC->DONE edge, so they are valid in DONE.
  - Next state is IDLE.
- Throughput: one instruction per 3 cycles. Latency from the accept edge to done_o is 2 cycles.
- rd==rs is legal. The operand is read before the write, so it sees the old value.
- Arithmetic wraps mod 2^16 inside the ALU; this stage does no width extension.
- Opcode encodings come from the shared config (OR=0, AND=1, XOR=2, SLL=3, SLR=4, NOT=5, NEG=6, ADD=7, SUB=8, CMP=9, MOV=10, MOVHI=11, MOVLO=12).

Decomposition:
- Shared include tangle_config.v holds:
  - opcode constants (existing).
  - new instruction field position constants (OPC_HI/LO, RD_HI/LO, RS_HI/LO, IMM_HI/LO).
  - FSM state encodings ST_IDLE, ST_EXEC, ST_DONE.
- One sub-module: tangle_regfile.
  - 8x16 registers.
  - 2 async read ports plus 1 debug read port.
  - 1 sync write port with synchronous clear.
- The top level instantiates tangle_regfile. The bench instantiates tangle_operand_stage together with the alu.

Test Plan:
- Reset then MOVHI r1,0x12; MOVLO r1,0x34 -> dbg r1=0x1234; done_o 2 cycles after each accept; instr_ready_o low for 2 cycles.
- r1=0xFFFF, r2=0x0001; ADD r1,r2 -> r1=0x0000; in DONE zf=1, cf=1, of=0, sf=0.
- r3=0x8000, r4=0x0001; CMP r3,r4 -> r3 stays 0x8000; of=1, sf=0, zf=0.
- SLL opcode with r5=0x00AA -> illegal_o=done_o=1; r5 unchanged; alu_en_o never high; flags unchanged.
- instr_valid_i held high across 3 instructions -> exactly 3 accepts at IDLE cycles; results XOR 0x000F^0x0019=0x0016 and NEG 3=0xFFFD are correct.
- rst_i asserted during EXEC of ADD -> no writeback, no done_o, all registers 0, instr_ready_o=1 next cycle.
